// File: rtl/fb_ifetch.sv
// rtl/fb_ifetch.sv - instruction-fetch stage: PC, imem req/ack fetch, IF/ID outputs
// Optional perf counters under FB_IFETCH_PERF_EN.
`ifndef FB_32BITS
`define FB_32BITS 32
`endif

module fb_ifetch #(
   parameter int             AW       = `FB_32BITS,
   parameter logic [AW-1:0]  RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall_i,
   input  logic          redirect_i,
   input  logic [AW-1:0] redirect_pc_i,
   output logic          imem_req_o,
   output logic [AW-1:0] imem_addr_o,
   input  logic          imem_ack_i,
   input  logic [31:0]   imem_rdata_i,
`ifdef FB_IFETCH_PERF_EN
   output logic [31:0]   perf_fetch_cnt_o,
   output logic [31:0]   perf_stall_cnt_o,
`endif
   output logic          if_we_o,
   output logic [AW-1:0] if_pc_o,
   output logic [AW-1:0] if_pc_add_1_o,
   output logic [31:0]   if_inst_o
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_VALID = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] req_addr_q;
   logic [AW-1:0] if_pc_q, if_pc_add_1_q;
   logic [31:0]   if_inst_q;
   logic          capture;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (redirect_i) begin
               state_d = imem_ack_i ? S_FETCH : S_DRAIN;
            end else if (imem_ack_i) begin
               state_d = S_VALID;
            end
         end
         S_VALID: begin
            if (redirect_i || !stall_i) begin
               state_d = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (imem_ack_i) begin
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   // In FETCH the address is the live pc; DRAIN keeps presenting the abandoned address.
   always_comb begin
      imem_req_o    = !rst && (state_q != S_VALID);
      imem_addr_o   = (state_q == S_FETCH) ? pc_q : req_addr_q;
      if_we_o       = (state_q == S_VALID);
      if_pc_o       = if_pc_q;
      if_pc_add_1_o = if_pc_add_1_q;
      if_inst_o     = if_inst_q;
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect_i) begin
         pc_d = redirect_pc_i;
      end else if ((state_q == S_VALID) && !stall_i) begin
         pc_d = pc_q + AW'(1);
      end
   end

   assign capture = (state_q == S_FETCH) && imem_ack_i && !redirect_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         req_addr_q    <= '0;
         if_pc_q       <= '0;
         if_pc_add_1_q <= '0;
         if_inst_q     <= '0;
      end else begin
         pc_q <= pc_d;
         if (state_q == S_FETCH) begin
            req_addr_q <= pc_q;
         end
         if (capture) begin
            if_pc_q       <= pc_q;
            if_pc_add_1_q <= pc_q + AW'(1);
            if_inst_q     <= imem_rdata_i;
         end
      end
   end

`ifdef FB_IFETCH_PERF_EN
   logic [31:0] perf_fetch_q, perf_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_q <= '0;
         perf_stall_q <= '0;
      end else if ((state_q == S_VALID) && !redirect_i) begin
         if (stall_i) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end else begin
            perf_fetch_q <= perf_fetch_q + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt_o = perf_fetch_q;
   assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fb_ifetch.sv
// tb/tb_fb_ifetch.sv - directed vector table plus randomized model check for fb_ifetch
module tb_fb_ifetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        if_we;
   logic [31:0] if_pc, if_pc_add_1, if_inst;

   logic        w_rst = 1'b1;
   logic        w_ack = 1'b0;
   logic [31:0] w_rdata = '0;
   logic        w_req, w_we;
   logic [31:0] w_addr, w_pc, w_pc_add_1, w_inst;

`ifdef FB_IFETCH_PERF_EN
   logic [31:0] perf_fetch, perf_stall, w_perf_fetch, w_perf_stall;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fb_ifetch #(.AW(32), .RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
      .redirect_pc_i(redirect_pc), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
`ifdef FB_IFETCH_PERF_EN
      .perf_fetch_cnt_o(perf_fetch), .perf_stall_cnt_o(perf_stall),
`endif
      .if_we_o(if_we), .if_pc_o(if_pc), .if_pc_add_1_o(if_pc_add_1), .if_inst_o(if_inst)
   );

   fb_ifetch #(.AW(32), .RESET_PC(32'hFFFF_FFFF)) u_wrap (
      .clk(clk), .rst(w_rst), .stall_i(1'b0), .redirect_i(1'b0),
      .redirect_pc_i(32'h0), .imem_req_o(w_req), .imem_addr_o(w_addr),
      .imem_ack_i(w_ack), .imem_rdata_i(w_rdata),
`ifdef FB_IFETCH_PERF_EN
      .perf_fetch_cnt_o(w_perf_fetch), .perf_stall_cnt_o(w_perf_stall),
`endif
      .if_we_o(w_we), .if_pc_o(w_pc), .if_pc_add_1_o(w_pc_add_1), .if_inst_o(w_inst)
   );

   typedef struct {
      bit          rst, stall, redir;
      logic [31:0] rpc;
      bit          ack;
      logic [31:0] rdata;
      bit          chk, ereq;
      logic [31:0] eaddr;
      bit          ewe;
      logic [31:0] epc, einst;
      bit          ctrip;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic add(input bit r, input bit s, input bit rd, input logic [31:0] rpc,
                      input bit a, input logic [31:0] dat, input bit c, input bit er,
                      input logic [31:0] ea, input bit ew, input logic [31:0] ep,
                      input logic [31:0] ei, input bit ct);
      vec_t v;
      v.rst = r; v.stall = s; v.redir = rd; v.rpc = rpc; v.ack = a; v.rdata = dat;
      v.chk = c; v.ereq = er; v.eaddr = ea; v.ewe = ew; v.epc = ep; v.einst = ei;
      v.ctrip = ct;
      vq.push_back(v);
   endtask

   // Fetch cycle: request outstanding at addr, nothing presented.
   task automatic f(input bit a, input logic [31:0] dat, input logic [31:0] addr);
      add(0, 0, 0, 0, a, dat, 1, 1, addr, 0, 0, 0, 0);
   endtask

   // Valid cycle: instruction presented, no request.
   task automatic v(input bit s, input logic [31:0] pc, input logic [31:0] inst);
      add(0, s, 0, 0, 0, 0, 1, 0, 0, 1, pc, inst, 0);
   endtask

   logic [31:0] m_pc, m_req_addr, m_tpc, m_tinst, e_addr;
   bit          m_have, m_stale, e_req;
   int unsigned lat;

   initial begin
      // reset, then zero-wait memory with rdata = addr + 0x100
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
      f(1, 32'h100, 0); v(0, 0, 32'h100);
      f(1, 32'h101, 1); v(0, 1, 32'h101);
      f(1, 32'h102, 2); v(0, 2, 32'h102);
      f(1, 32'h103, 3); v(0, 3, 32'h103);
      f(1, 32'h104, 4); v(0, 4, 32'h104);
      // 3-cycle ack latency at addr 5
      f(0, 0, 5); f(0, 0, 5); f(1, 32'h205, 5); v(0, 5, 32'h205);
      f(1, 32'h206, 6); v(0, 6, 32'h206);
      f(1, 32'h207, 7);
      // stall 4 cycles in VALID at pc 7
      v(1, 7, 32'h207); v(1, 7, 32'h207); v(1, 7, 32'h207); v(1, 7, 32'h207);
      v(0, 7, 32'h207);
      f(1, 32'h208, 8); v(0, 8, 32'h208);
      // redirect to 0x40 while fetch of 9 is outstanding
      add(0, 0, 1, 32'h40, 0, 0, 1, 1, 9, 0, 0, 0, 0);
      f(0, 0, 9); f(1, 32'hDEAD, 9);
      f(1, 32'h140, 32'h40);
      // redirect in VALID overrides stall; then redirect coinciding with ack at addr 3
      add(0, 1, 1, 3, 0, 0, 1, 0, 0, 1, 32'h40, 32'h140, 0);
      add(0, 0, 1, 32'h20, 1, 32'hBAD, 1, 1, 3, 0, 0, 0, 0);
      f(0, 0, 32'h20); f(1, 32'h120, 32'h20); v(0, 32'h20, 32'h120);
      // two redirects while draining: only the last target is fetched
      add(0, 0, 1, 32'h50, 0, 0, 1, 1, 32'h21, 0, 0, 0, 0);
      add(0, 0, 1, 32'h60, 0, 0, 1, 1, 32'h21, 0, 0, 0, 0);
      f(1, 32'hBEEF, 32'h21); f(1, 32'h160, 32'h60);
      // spurious ack while idle is ignored
      add(0, 1, 0, 0, 1, 32'hBAD, 1, 0, 0, 1, 32'h60, 32'h160, 0);
      v(0, 32'h60, 32'h160);
      // reset mid-request
      add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
      f(1, 32'h100, 0); v(0, 0, 32'h100);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         rst = vq[i].rst; stall = vq[i].stall; redirect = vq[i].redir;
         redirect_pc = vq[i].rpc; imem_ack = vq[i].ack; imem_rdata = vq[i].rdata;
         #1;
         if (vq[i].chk) begin
            check($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vq[i].ereq});
            if (vq[i].ereq) check($sformatf("v%0d_addr", i), imem_addr, vq[i].eaddr);
            check($sformatf("v%0d_we", i), {31'd0, if_we}, {31'd0, vq[i].ewe});
            if (vq[i].ewe) begin
               check($sformatf("v%0d_pc", i), if_pc, vq[i].epc);
               check($sformatf("v%0d_pc1", i), if_pc_add_1, vq[i].epc + 32'd1);
               check($sformatf("v%0d_inst", i), if_inst, vq[i].einst);
            end else if (vq[i].ctrip) begin
               check($sformatf("v%0d_rpc", i), if_pc, 32'd0);
               check($sformatf("v%0d_rpc1", i), if_pc_add_1, 32'd0);
               check($sformatf("v%0d_rinst", i), if_inst, 32'd0);
            end
         end
`ifdef FB_IFETCH_PERF_EN
         if (i == 24) begin
            check("perf_fetch", perf_fetch, 32'd8);
            check("perf_stall", perf_stall, 32'd4);
         end
`endif
      end

      // randomized run against a transaction-level model
      m_pc = 0; m_req_addr = 0; m_tpc = 0; m_tinst = 0; m_have = 0; m_stale = 0; lat = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst = (i == 0) || ($urandom_range(199) == 0);
         stall = ($urandom_range(9) < 4);
         redirect = ($urandom_range(9) == 0);
         redirect_pc = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(255));
         e_req = !rst && !m_have;
         e_addr = m_stale ? m_req_addr : m_pc;
         imem_ack = e_req ? (lat == 0) : ($urandom_range(19) == 0);
         imem_rdata = e_req ? (e_addr * 32'd3 + 32'h7) : $urandom;
         #1;
         if (i > 0) begin
            check("rnd_req", {31'd0, imem_req}, {31'd0, e_req});
            if (e_req) check("rnd_addr", imem_addr, e_addr);
            check("rnd_we", {31'd0, if_we}, {31'd0, m_have});
            if (m_have) begin
               check("rnd_pc", if_pc, m_tpc);
               check("rnd_pc1", if_pc_add_1, m_tpc + 32'd1);
               check("rnd_inst", if_inst, m_tinst);
            end
         end
         if (e_req) lat = imem_ack ? $urandom_range(3) : lat - 1;
         if (rst) begin
            m_pc = 0; m_have = 0; m_stale = 0; m_req_addr = 0; lat = $urandom_range(3);
         end else if (m_have) begin
            if (redirect) begin
               m_pc = redirect_pc; m_have = 0;
            end else if (!stall) begin
               m_pc = m_pc + 32'd1; m_have = 0;
            end
         end else if (redirect) begin
            if (!imem_ack) begin
               if (!m_stale) m_req_addr = m_pc;
               m_stale = 1;
            end else begin
               m_stale = 0;
            end
            m_pc = redirect_pc;
         end else if (imem_ack) begin
            if (m_stale) begin
               m_stale = 0;
            end else begin
               m_tpc = m_pc; m_tinst = imem_rdata; m_have = 1;
            end
         end
      end

      // wrap instance: RESET_PC = 0xFFFFFFFF
      @(negedge clk); w_rst = 1;
      @(negedge clk); w_rst = 0; w_ack = 1; w_rdata = 32'h77;
      #1;
      check("wrap_req", {31'd0, w_req}, 32'd1);
      check("wrap_addr", w_addr, 32'hFFFF_FFFF);
      @(negedge clk); w_ack = 0;
      #1;
      check("wrap_we", {31'd0, w_we}, 32'd1);
      check("wrap_pc", w_pc, 32'hFFFF_FFFF);
      check("wrap_pc1", w_pc_add_1, 32'd0);
      check("wrap_inst", w_inst, 32'h77);
      @(negedge clk);
      #1;
      check("wrap_next_addr", w_addr, 32'd0);
      check("wrap_next_req", {31'd0, w_req}, 32'd1);
      @(negedge clk); w_rst = 1;
      #1;
      check("wrap_rst_req", {31'd0, w_req}, 32'd0);
      @(negedge clk); w_rst = 0;
      #1;
      check("wrap_rst_we", {31'd0, w_we}, 32'd0);
      check("wrap_rst_addr", w_addr, 32'hFFFF_FFFF);
      check("wrap_rst_pc", w_pc, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fb_ifetch.md
Name: fb_ifetch

Overview:
- Instruction-fetch stage. Owns the program counter and issues word-addressed fetches to instruction memory over a req/ack handshake.
- Presents pc, pc+1 and the fetched instruction to the IF/ID register, qualified by a write-enable.
- Honours the hazard unit's stall (the same signal that drives IF/ID lock) and the branch-resolution redirect, which also drives IF/ID rst.
- Discards any in-flight fetch that a redirect makes stale.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Word address.
- AW, 32, PC / address width. Equals `FB_32BITS.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit holds fetch; same net as IF/ID lock.
- redirect  input  1  taken branch/jump or misprediction; loads redirect_pc.
- redirect_pc  input  AW  new word-address PC.
- imem_req  output  1  fetch request.
- imem_addr  output  AW  fetch word address.
- imem_ack  input  1  single-cycle pulse; imem_rdata valid this cycle.
- imem_rdata  input  32  fetched instruction.
- if_we  output  1  outputs valid; drives IF/ID we.
- if_pc  output  AW  PC of the presented instruction.
- if_pc_add_1  output  AW  if_pc + 1, for jal/jalr link.
- if_inst  output  32  presented instruction.

Behaviour:
- Reset (rst=1 at posedge) overrides everything:
  - pc<=RESET_PC, state<=FETCH.
  - if_we<=0, if_pc<=0, if_pc_add_1<=0, if_inst<=0.
  - req_addr<=0.
  - imem_req=0 during the reset cycle.
- Reset is allowed mid-request. The memory must tolerate an abandoned request; a later stale ack in FETCH is impossible by system contract.
- Handshake rules:
  - Once imem_req=1, it stays high and imem_addr (driven from req_addr) stays stable until the cycle imem_ack=1.
  - ack may come in the same cycle req first rises: zero-wait memory.
  - ack is never expected while imem_req=0; if it arrives, it is ignored.
- State FETCH:
  - imem_req=1, imem_addr=req_addr=pc (req_addr latched on entry).
  - if_we=0.
  - On ack with no redirect: if_inst<=imem_rdata, if_pc<=pc, if_pc_add_1<=pc+1, if_we<=1, go VALID.
- State VALID:
  - Outputs held, if_we=1, imem_req=0.
  - stall=1: hold everything, including pc.
  - stall=0: IF/ID captures this edge; pc<=pc+1, if_we<=0, go FETCH.
- State DRAIN:
  - imem_req=1, imem_addr=req_addr (old address), if_we=0.
  - On ack: data dropped, go FETCH (new pc already loaded).
- Redirect priority: above stall and above ack.
  - In every state: pc<=redirect_pc and if_we<=0 next cycle.
  - FETCH with no ack this cycle: go DRAIN.
  - FETCH with ack this cycle: data dropped, go FETCH.
  - VALID: go FETCH; stall is ignored.
  - DRAIN with no ack: stay DRAIN. A later redirect overwrites pc again; only the last redirect target is fetched.
  - DRAIN with ack: go FETCH.
- Stall during FETCH or DRAIN has no effect; the request completes. Stall only freezes VALID.
- Arithmetic: pc+1 and if_pc_add_1 wrap modulo 2^AW (32'hFFFF_FFFF+1 = 0). No alignment checks.
- Latency and throughput:
  - Zero-wait memory: 1 cycle FETCH + 1 cycle VALID per instruction, so max 1 instruction every 2 cycles.
  - First if_we=1 appears in the cycle after the first ack.
  - Redirect to first valid, zero-wait memory: 2 cycles (FETCH, then VALID).

Optional Feature:
- Macro FB_IFETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both cleared on rst.
  - perf_fetch_cnt increments on each VALID->FETCH transition with stall=0 and no redirect (instruction delivered).
  - perf_stall_cnt increments each cycle in VALID with stall=1 and no redirect.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, zero-wait memory returning rdata=addr+32'h100, stall=0:
  - imem_addr sequence 0,1,2,3.
  - if_we pulses every other cycle with (if_pc, if_pc_add_1, if_inst) = (0,1,0x100), (1,2,0x101), ...
- Memory with 3-cycle ack latency:
  - imem_req stays high for 3 cycles with imem_addr=5 stable.
  - if_we=1 the cycle after ack, with if_pc=5.
- stall=1 for 4 cycles while in VALID at pc=7:
  - if_we, if_pc=7 and if_inst held; no imem_req.
  - After release, next imem_addr=8. With the PERF macro, perf_stall_cnt=4.
- Redirect to 32'h40 while a 3-cycle fetch of addr 9 is outstanding:
  - imem_req stays high with imem_addr=9 until ack; that data is never presented (if_we=0).
  - Then imem_addr=32'h40, and the presented if_pc=32'h40.
- Redirect together with ack in FETCH at addr 3, redirect_pc=32'h20:
  - No if_we for addr 3.
  - Next request imem_addr=32'h20.
- Wrap: RESET_PC=32'hFFFF_FFFF:
  - First presented if_pc_add_1=0.
  - Next imem_addr=0.
  - rst asserted mid-request clears if_we and restarts at RESET_PC.
